// File: rtl/lvds_pkg.sv
// Shared LVDS I/Q definitions: word sync patterns, idle word, word length
// and the serializer FSM encoding. Used by lvds_tx and lvds_rx.
package lvds_pkg;

    // Sync patterns carried in each 32-bit I/Q word.
    localparam logic [1:0]  SYNC_I      = 2'b10;
    localparam logic [1:0]  SYNC_Q      = 2'b01;

    // Word sent when the FIFO runs dry while streaming. It has no valid
    // sync, so the modem discards it.
    localparam logic [31:0] IDLE_WORD   = 32'h0000_0000;

    // Two bits per clock, so a 32-bit word takes 16 clocks.
    localparam int          WORD_PHASES = 16;
    localparam int          PHASE_W     = 4;

    // The FIFO is read one phase before the last one. Its data then
    // arrives just in time to be loaded at the word boundary.
    localparam logic [PHASE_W-1:0] PULL_PHASE = 4'd14;
    localparam logic [PHASE_W-1:0] LAST_PHASE = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } lvds_state_t;

    // Overwrite both sync fields of a word with the fixed patterns.
    function automatic logic [31:0] insert_sync(input logic [31:0] word);
        logic [31:0] res;
        res        = word;
        res[31:30] = SYNC_I;
        res[15:14] = SYNC_Q;
        return res;
    endfunction

endpackage

// File: rtl/lvds_tx.sv
// LVDS I/Q transmit serializer. Reads 32-bit words from the TX FIFO and
// shifts them out MSB-first, two bits per clock, to a DDR output cell.
// Optional build macro LVDS_TX_SYNC_INSERT_EN: force the I/Q sync fields
// of every word loaded from the FIFO. Idle words stay all-zero.
//
// FIFO handshake: o_fifo_pull is a one-cycle read strobe. It is only
// raised when i_fifo_empty is low. i_fifo_data is valid in the cycle
// after the strobe. There is at most one pull per word.
module lvds_tx
    import lvds_pkg::*;
#(
    parameter int UNDERRUN_W = 8
) (
    input  logic                  i_ddr_clk,
    input  logic                  i_rst_b,
    input  logic                  i_tx_en,
    input  logic                  i_fifo_empty,
    input  logic [31:0]           i_fifo_data,
    output logic                  o_fifo_pull,
    output logic                  o_ddr_d0,
    output logic                  o_ddr_d1,
    output logic                  o_busy,
    output logic [UNDERRUN_W-1:0] o_underrun_cnt,
    output lvds_state_t           o_dbg_state
);

    lvds_state_t          state, state_nxt;
    logic [31:0]          sr, sr_nxt;
    logic [PHASE_W-1:0]   phase, phase_nxt;
    logic                 pulled, pulled_nxt;
    logic                 underrun_inc;
    logic                 fifo_pull;
    logic [31:0]          load_word;
    logic [UNDERRUN_W-1:0] underrun_cnt;

    // Pick the word to load from the FIFO: verbatim, or with sync forced.
`ifdef LVDS_TX_SYNC_INSERT_EN
    assign load_word = insert_sync(i_fifo_data);
`else
    assign load_word = i_fifo_data;
`endif

    // Register the FSM state, shifter, phase counter and pull flag.
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state  <= ST_IDLE;
            sr     <= IDLE_WORD;
            phase  <= '0;
            pulled <= 1'b0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            phase  <= phase_nxt;
            pulled <= pulled_nxt;
        end
    end

    // Next state, next shifter contents and the FIFO read strobe.
    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        phase_nxt    = phase;
        pulled_nxt   = pulled;
        fifo_pull    = 1'b0;
        underrun_inc = 1'b0;

        case (state)
            ST_IDLE: begin
                sr_nxt     = IDLE_WORD;
                phase_nxt  = '0;
                pulled_nxt = 1'b0;
                if (i_tx_en && !i_fifo_empty) begin
                    fifo_pull = 1'b1;
                    state_nxt = ST_PRIME;
                end
            end

            ST_PRIME: begin
                // FIFO data is valid now, one cycle after the pull.
                sr_nxt    = load_word;
                phase_nxt = '0;
                state_nxt = ST_STREAM;
            end

            ST_STREAM: begin
                sr_nxt    = sr << 2;
                phase_nxt = phase + 4'd1;

                if (phase == PULL_PHASE && i_tx_en && !i_fifo_empty) begin
                    fifo_pull  = 1'b1;
                    pulled_nxt = 1'b1;
                end

                if (phase == LAST_PHASE) begin
                    pulled_nxt = 1'b0;
                    if (pulled) begin
                        sr_nxt = load_word;
                    end else if (i_tx_en) begin
                        // Nothing was available: fill the slot with an idle word.
                        sr_nxt       = IDLE_WORD;
                        underrun_inc = 1'b1;
                    end else begin
                        sr_nxt    = IDLE_WORD;
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                sr_nxt     = IDLE_WORD;
                phase_nxt  = '0;
                pulled_nxt = 1'b0;
            end
        endcase
    end

    // Count idle words inserted while streaming. Saturate at all-ones.
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            underrun_cnt <= '0;
        end else if (underrun_inc && (underrun_cnt != {UNDERRUN_W{1'b1}})) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    assign o_fifo_pull    = fifo_pull;
    assign o_ddr_d0       = sr[31];
    assign o_ddr_d1       = sr[30];
    assign o_busy         = (state != ST_IDLE);
    assign o_underrun_cnt = underrun_cnt;
    assign o_dbg_state    = state;

endmodule

// File: tb/tb_lvds_tx.sv
// Directed testbench for lvds_tx. A small FIFO model feeds the DUT, and
// the DDR bit pairs are reassembled into words. Each word is compared
// with a hand-computed expected value.
module tb_lvds_tx;
    import lvds_pkg::*;

    logic        clk;
    logic        rst_b;
    logic        tx_en;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        pull;
    logic        d0;
    logic        d1;
    logic        busy;
    logic [7:0]  ucnt;
    lvds_state_t dbg_state;

    int total = 0;
    int bad   = 0;

    // FIFO model: the bench writes at negedge, and the DUT reads at posedge.
    logic [31:0] fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          cyc = 0;
    int          pull_cnt = 0;
    int          pull_cyc[$];

    lvds_tx #(.UNDERRUN_W(8)) dut (
        .i_ddr_clk      (clk),
        .i_rst_b        (rst_b),
        .i_tx_en        (tx_en),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_data    (fifo_data),
        .o_fifo_pull    (pull),
        .o_ddr_d0       (d0),
        .o_ddr_d1       (d1),
        .o_busy         (busy),
        .o_underrun_cnt (ucnt),
        .o_dbg_state    (dbg_state)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (pull) begin
            fifo_data <= fifo_mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
            pull_cnt  <= pull_cnt + 1;
            pull_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_b  = 1'b0;
        tx_en  = 1'b0;
        wr_ptr = rd_ptr;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Return 1 with time just past a negedge in the cycle where pull is high.
    task automatic wait_pull(output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (pull) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic capture_word(output logic [31:0] w);
        w = 32'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            w = {w[29:0], d0, d1};
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit seen_pull;
        rst_b = 1'b0;
        tx_en = 1'b0;
        #3;
        total++; if (d0 !== 1'b0 || d1 !== 1'b0) begin bad++; $display("FAIL reset_ddr got=%b%b exp=00", d0, d1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (pull !== 1'b0) begin bad++; $display("FAIL reset_pull got=%b exp=0", pull); end
        total++; if (ucnt !== 8'd0) begin bad++; $display("FAIL reset_ucnt got=%0d exp=0", ucnt); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        do_reset();
        // Enabled with an empty FIFO: never pull, stay idle.
        tx_en = 1'b1;
        seen_pull = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pull) seen_pull = 1'b1;
        end
        total++; if (seen_pull !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL empty_no_pull got pull=%b busy=%b exp 0/0", seen_pull, busy); end
        tx_en = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int p0;
        logic [31:0] w;
        do_reset();
        p0 = pull_cnt;
        push(32'h8002_4001);
        tx_en = 1'b1;
        wait_pull(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_pull_timeout got=none exp=pull"); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_at_pull got=%b exp=0", busy); end
        @(negedge clk);
        tx_en = 1'b0;
        total++; if (dbg_state !== ST_PRIME || busy !== 1'b1) begin bad++; $display("FAIL single_prime got state=%0d busy=%b exp=1/1", dbg_state, busy); end
        capture_word(w);
        total++; if (w !== 32'h8002_4001) begin bad++; $display("FAIL single_word got=%h exp=80024001", w); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || d0 !== 1'b0 || d1 !== 1'b0) begin bad++; $display("FAIL single_idle got busy=%b d=%b%b exp=0/00", busy, d0, d1); end
        total++; if (pull_cnt - p0 !== 1) begin bad++; $display("FAIL single_pulls got=%0d exp=1", pull_cnt - p0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int p0;
        int q0;
        logic [31:0] w1, w2, w3;
        do_reset();
        p0 = pull_cnt;
        q0 = pull_cyc.size();
        push(32'h9234_5678);
        push(32'hA5A5_4C3B);
        push(32'h8001_7FFE);
        tx_en = 1'b1;
        wait_pull(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_pull_timeout got=none exp=pull"); end
        @(negedge clk);
        capture_word(w1);
        capture_word(w2);
        tx_en = 1'b0;
        capture_word(w3);
        total++; if (w1 !== 32'h9234_5678) begin bad++; $display("FAIL b2b_w1 got=%h exp=92345678", w1); end
        total++; if (w2 !== 32'hA5A5_4C3B) begin bad++; $display("FAIL b2b_w2 got=%h exp=a5a54c3b", w2); end
        total++; if (w3 !== 32'h8001_7FFE) begin bad++; $display("FAIL b2b_w3 got=%h exp=80017ffe", w3); end
        @(negedge clk);
        total++; if (pull_cnt - p0 !== 3) begin bad++; $display("FAIL b2b_pulls got=%0d exp=3", pull_cnt - p0); end
        if (pull_cyc.size() >= q0 + 3) begin
            total++; if (pull_cyc[q0+1] - pull_cyc[q0] !== 16) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=16", pull_cyc[q0+1] - pull_cyc[q0]); end
            total++; if (pull_cyc[q0+2] - pull_cyc[q0+1] !== 16) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=16", pull_cyc[q0+2] - pull_cyc[q0+1]); end
        end
        total++; if (busy !== 1'b0 || ucnt !== 8'd0) begin bad++; $display("FAIL b2b_end got busy=%b ucnt=%0d exp=0/0", busy, ucnt); end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [31:0] wa, wi, wb;
        do_reset();
        push(32'h8123_4456);
        tx_en = 1'b1;
        wait_pull(ok);
        total++; if (!ok) begin bad++; $display("FAIL under_pull_timeout got=none exp=pull"); end
        @(negedge clk);
        capture_word(wa);
        push(32'hBFFF_4001);
        capture_word(wi);
        total++; if (ucnt !== 8'd1) begin bad++; $display("FAIL under_cnt got=%0d exp=1", ucnt); end
        tx_en = 1'b0;
        capture_word(wb);
        total++; if (wa !== 32'h8123_4456) begin bad++; $display("FAIL under_wa got=%h exp=81234456", wa); end
        total++; if (wi !== 32'h0) begin bad++; $display("FAIL under_idle got=%h exp=00000000", wi); end
        total++; if (wb !== 32'hBFFF_4001) begin bad++; $display("FAIL under_wb got=%h exp=bfff4001", wb); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || ucnt !== 8'd1) begin bad++; $display("FAIL under_end got busy=%b ucnt=%0d exp=0/1", busy, ucnt); end
    endtask

    task automatic test_disable_mid();
        bit ok;
        int p0;
        logic [31:0] w;
        do_reset();
        p0 = pull_cnt;
        push(32'h8765_4321);
        push(32'h8000_4000);
        tx_en = 1'b1;
        wait_pull(ok);
        total++; if (!ok) begin bad++; $display("FAIL dis_pull_timeout got=none exp=pull"); end
        @(negedge clk);
        w = 32'h0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) tx_en = 1'b0;
            @(negedge clk);
            w = {w[29:0], d0, d1};
        end
        total++; if (w !== 32'h8765_4321) begin bad++; $display("FAIL dis_word got=%h exp=87654321", w); end
        @(negedge clk);
        total++; if (dbg_state !== ST_IDLE || busy !== 1'b0 || d0 !== 1'b0 || d1 !== 1'b0) begin bad++; $display("FAIL dis_idle got state=%0d busy=%b d=%b%b exp=0/0/00", dbg_state, busy, d0, d1); end
        total++; if (pull_cnt - p0 !== 1) begin bad++; $display("FAIL dis_pulls got=%0d exp=1", pull_cnt - p0); end
    endtask

    task automatic test_saturate();
        bit ok;
        int p0;
        do_reset();
        p0 = pull_cnt;
        push(32'h8000_4000);
        tx_en = 1'b1;
        wait_pull(ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_pull_timeout got=none exp=pull"); end
        repeat (17 + 300 * 16 + 8) @(negedge clk);
        total++; if (ucnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", ucnt); end
        total++; if (busy !== 1'b1 || pull_cnt - p0 !== 1) begin bad++; $display("FAIL sat_stream got busy=%b pulls=%0d exp=1/1", busy, pull_cnt - p0); end
        tx_en = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (busy !== 1'b0 || ucnt !== 8'd255) begin bad++; $display("FAIL sat_hold got busy=%b ucnt=%0d exp=0/255", busy, ucnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] w;
        logic [31:0] exp_w;
        do_reset();
        push(32'hFFFF_FFFF);
        tx_en = 1'b1;
        wait_pull(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_pull_timeout got=none exp=pull"); end
        @(negedge clk);
        repeat (8) @(negedge clk);   // now in phase 7
        total++; if (d0 !== 1'b1 || d1 !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rmid_before got d=%b%b busy=%b exp=11/1", d0, d1, busy); end
        rst_b = 1'b0;
        #1;
        total++; if (d0 !== 1'b0 || d1 !== 1'b0 || busy !== 1'b0 || pull !== 1'b0 || ucnt !== 8'd0) begin bad++; $display("FAIL rmid_async got d=%b%b busy=%b pull=%b ucnt=%0d exp all 0", d0, d1, busy, pull, ucnt); end
        do_reset();
        // Sync insertion check on an all-ones FIFO word.
`ifdef LVDS_TX_SYNC_INSERT_EN
        exp_w = 32'hBFFF_7FFF;
`else
        exp_w = 32'hFFFF_FFFF;
`endif
        push(32'hFFFF_FFFF);
        tx_en = 1'b1;
        wait_pull(ok);
        total++; if (!ok) begin bad++; $display("FAIL sync_pull_timeout got=none exp=pull"); end
        @(negedge clk);
        tx_en = 1'b0;
        capture_word(w);
        total++; if (w !== exp_w) begin bad++; $display("FAIL sync_word got=%h exp=%h", w, exp_w); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst_b     = 1'b0;
        tx_en     = 1'b0;
        fifo_data = 32'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_disable_mid();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lvds_tx.md
# lvds_tx

Transmit-side LVDS I/Q serializer for the modem TX path. Pulls 32-bit I/Q words from the TX complex FIFO and emits them MSB-first, two bits per clock, to a DDR output SB_IO driving `o_iq_tx_p/n`. Word format and bit order mirror `lvds_rx`, so a `lvds_tx` → `lvds_rx` loopback reproduces the FIFO words exactly. Top level forwards `i_ddr_clk` to `o_iq_tx_clk_p/n`.

## Interface
Parameters:
- `UNDERRUN_W`, 8: width of the saturating underrun counter.

Ports:
- `i_ddr_clk`  in  1  DDR bit clock (modem LVDS clock domain); sole clock.
- `i_rst_b`  in  1  reset, asynchronous, active-low.
- `i_tx_en`  in  1  streaming enable, already synchronous to `i_ddr_clk`; sampled only at word boundaries.
- `i_fifo_empty`  in  1  TX FIFO empty flag.
- `i_fifo_data`  in  32  FIFO read data, valid the cycle after `o_fifo_pull`.
- `o_fifo_pull`  out  1  one-cycle FIFO read strobe.
- `o_ddr_d0`  out  1  to SB_IO `D_OUT_0` (rising-edge bit, even/MSB of pair).
- `o_ddr_d1`  out  1  to SB_IO `D_OUT_1` (falling-edge bit).
- `o_busy`  out  1  high whenever state ≠ ST_IDLE.
- `o_underrun_cnt`  out  UNDERRUN_W  count of idle words inserted while streaming.

## Operation
- Word format: [31:30] I sync 2'b10, [29:17] I, [16] ctrl, [15:14] Q sync 2'b01, [13:1] Q, [0] ctrl.
- 32-bit shift register `sr`, 4-bit phase counter 0..15; `o_ddr_d0 = sr[31]`, `o_ddr_d1 = sr[30]` (direct from register, no extra stage).
- ST_IDLE: `sr` = 0, phase = 0. If `i_tx_en && !i_fifo_empty`: pulse `o_fifo_pull`, go ST_PRIME.
- ST_PRIME (one cycle): `sr <= i_fifo_data`, phase = 0, go ST_STREAM.
- ST_STREAM: each cycle `sr <= sr << 2`, phase++ (wraps 15→0).
  - Phase 14: if `i_tx_en && !i_fifo_empty` pulse `o_fifo_pull`, set `pulled`; else no pull.
  - Phase 15: if `pulled`, `sr <= i_fifo_data`; else if `i_tx_en`, `sr <= 32'h0` (idle word) and counter +1; else (`!i_tx_en`) `sr <= 0`, go ST_IDLE. `pulled` clears.
- Back-to-back words: no gap; 16 cycles per word.
- `i_tx_en` deassert mid-word: current word completes; no further pulls.
- FIFO empty at phase 14 while enabled: one zero word sent (no valid sync → modem ignores), streaming continues, retries at next phase 14.
- Underrun counter saturates at 2^UNDERRUN_W−1; cleared only by reset.
- Never pulls when `i_fifo_empty` = 1; at most one pull per word.

## Timing
- Reset (async, immediate): state ST_IDLE, `sr` = 0, phase = 0, `o_ddr_d0/d1` = 0, `o_fifo_pull` = 0, `o_busy` = 0, `o_underrun_cnt` = 0. Mid-word reset drops the word.
- Start latency: pull at cycle N, load at N+1, bits [31:30] on outputs at N+2.
- Steady state: word bits [31:30] appear the cycle after phase 15; pull-to-first-bit = 2 cycles.
- `o_busy` rises with entry to ST_PRIME, falls on entry to ST_IDLE.

## Configuration
- `LVDS_TX_SYNC_INSERT_EN` defined: on every FIFO load, bits [31:30] forced to 2'b10 and [15:14] to 2'b01, regardless of FIFO content; idle words stay all-zero.
- Undefined: FIFO words transmitted verbatim, sync bits are the writer's responsibility.

## Structure
- Shared package `lvds_pkg`: `SYNC_I` (2'b10), `SYNC_Q` (2'b01), `IDLE_WORD` (32'h0), `WORD_PHASES` (16), state encoding (ST_IDLE, ST_PRIME, ST_STREAM); reused by `lvds_rx`.
- No sub-module; FSM, shifter and counter stay in one module.

## Test plan
- Reset, enable, FIFO holds 0x8002_4001 → pull once, outputs after 2 cycles give pairs 2'b10,00,00,… bit-exact MSB-first over 16 cycles, `o_busy` = 1.
- Three words queued back-to-back → exactly 3 pulls spaced 16 cycles, 48 contiguous bit-pairs, no gap; loopback through `lvds_rx` returns identical words.
- FIFO empties after word 1 with `i_tx_en` = 1 → one all-zero word, `o_underrun_cnt` = 1, streaming resumes when data arrives.
- Deassert `i_tx_en` at phase 5 → word completes, no pull at phase 14, ST_IDLE after phase 15, outputs 0.
- Force 300 underruns with UNDERRUN_W = 8 → counter holds 255.
- Assert `i_rst_b` = 0 at phase 7 → all outputs 0 immediately; with macro defined, FIFO word 0xFFFF_FFFF transmits as 0xBFFF_7FFF.
